// File: rtl/mul4_eval_pkg.sv
// Shared types and helpers for evaluating evolved mul4 candidates.
package mul4_eval_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } eval_state_t;

  typedef logic [15:0] word_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Number of matching words in a 4-bit match vector.
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/mul4_stim_lfsr.sv
// Stimulus LFSR: one advance consumes a full operand pair (two steps), so
// state_o and next_o are the A and B operands of the current vector.
module mul4_stim_lfsr
  import mul4_eval_pkg::*;
#(
  parameter logic [31:0] DEF_SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        adv_i,
  output logic [31:0] state_o,
  output logic [31:0] next_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  // Seed load (0 is a lock-up state, so it is replaced) or two-step advance.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 32'h0) ? DEF_SEED : seed_i;
    end else if (adv_i) begin
      state_d = lfsr_next(lfsr_next(state_q));
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 32'h0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign next_o  = lfsr_next(state_q);

endmodule

// File: rtl/mul4_fitness_sequencer.sv
// Drives LFSR operands into one mul4 candidate, compares its four result
// words against a registered 64-bit golden product and accumulates scores.
module mul4_fitness_sequencer
  import mul4_eval_pkg::*;
#(
  parameter int          N_VECTORS = 16,
  parameter int          DUT_LAT   = 0,
  parameter logic [31:0] DEF_SEED  = 32'h1,
  localparam int         SW_W      = $clog2(4*N_VECTORS+1),
  localparam int         SV_W      = $clog2(N_VECTORS+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     seed,
  output logic            busy,
  output logic            done,
  output logic [SW_W-1:0] score_words,
  output logic [SV_W-1:0] score_vectors,
  output word_t           dut_a1,
  output word_t           dut_a0,
  output word_t           dut_b1,
  output word_t           dut_b0,
  input  word_t           dut_y3,
  input  word_t           dut_y2,
  input  word_t           dut_y1,
  input  word_t           dut_y0
);

  localparam int                VI_W    = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;
  localparam int                WC_W    = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [VI_W-1:0]   VI_LAST = VI_W'(N_VECTORS - 1);
  localparam logic [WC_W-1:0]   WC_LAST = (DUT_LAT > 0) ? WC_W'(DUT_LAT - 1) : '0;

  eval_state_t     state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SW_W-1:0] sw_q, sw_d;
  logic [SV_W-1:0] sv_q, sv_d;
  logic [VI_W-1:0] vec_q, vec_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [31:0]     op_a_q, op_b_q;
  logic [63:0]     gold_q;

  logic            lfsr_load;
  logic            lfsr_adv;
  logic            ops_load;
  logic            gold_en;
  logic [31:0]     lfsr_state;
  logic [31:0]     lfsr_nxt;
  logic [3:0]      match;

  mul4_stim_lfsr #(
    .DEF_SEED(DEF_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .seed_i (seed),
    .adv_i  (lfsr_adv),
    .state_o(lfsr_state),
    .next_o (lfsr_nxt)
  );

  // Per-word comparison; only consumed while in CHECK.
  assign match[0] = (dut_y0 == gold_q[15:0]);
  assign match[1] = (dut_y1 == gold_q[31:16]);
  assign match[2] = (dut_y2 == gold_q[47:32]);
  assign match[3] = (dut_y3 == gold_q[63:48]);

  // Next-state, score accumulation and datapath enables.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sw_d      = sw_q;
    sv_d      = sv_q;
    vec_d     = vec_q;
    wcnt_d    = wcnt_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    ops_load  = 1'b0;
    gold_en   = 1'b0;
    if ((state_q != IDLE) && abort) begin
      // Partial scores are left as they are; no done pulse.
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d   = LOAD;
            busy_d    = 1'b1;
            sw_d      = '0;
            sv_d      = '0;
            vec_d     = '0;
            lfsr_load = 1'b1;
          end
        end
        LOAD: begin
          ops_load = 1'b1;
          lfsr_adv = 1'b1;
          state_d  = DRIVE;
        end
        DRIVE: begin
          gold_en = 1'b1;
          wcnt_d  = '0;
          state_d = (DUT_LAT == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (wcnt_q == WC_LAST) begin
            state_d = CHECK;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
        CHECK: begin
          sw_d = sw_q + SW_W'(popcount4(match));
          sv_d = sv_q + SV_W'(match == 4'hF);
          if (vec_q == VI_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d    = vec_q + VI_W'(1);
            ops_load = 1'b1;
            lfsr_adv = 1'b1;
            state_d  = DRIVE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Control, score and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sw_q    <= '0;
      sv_q    <= '0;
      vec_q   <= '0;
      wcnt_q  <= '0;
      op_a_q  <= 32'h0;
      op_b_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sw_q    <= sw_d;
      sv_q    <= sv_d;
      vec_q   <= vec_d;
      wcnt_q  <= wcnt_d;
      if (ops_load) begin
        op_a_q <= lfsr_state;
        op_b_q <= lfsr_nxt;
      end
    end
  end

  // Golden product, captured while the operands are first presented.
  always_ff @(posedge clk) begin
    if (gold_en) begin
      gold_q <= 64'(op_a_q) * 64'(op_b_q);
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign score_words   = sw_q;
  assign score_vectors = sv_q;
  assign dut_a1        = op_a_q[31:16];
  assign dut_a0        = op_a_q[15:0];
  assign dut_b1        = op_b_q[31:16];
  assign dut_b0        = op_b_q[15:0];

endmodule
